mult_div_sequencer: RTL

MULT_DIV_SEQUENCER -- requirements
Module: mult_div_sequencer

---
 rtl/mult_div_sequencer_if.sv | 23 ++
 rtl/mult_div_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mult_div_sequencer_if.sv
// rtl/mult_div_sequencer_if.sv - request/result bundle for the HI/LO multiply-divide sequencer
interface mult_div_sequencer_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_data, rt_data, flush,
        input  busy, stall, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, flush,
        output busy, stall, done, hi, lo
    );
endinterface

// File: rtl/mult_div_sequencer.sv
// rtl/mult_div_sequencer.sv - radix-2 MULT/MULTU/DIV/DIVU sequencer with HI/LO, optional MULDIV_EARLY_OUT_EN
module mult_div_sequencer (
    input  logic               clk,
    input  logic               rst_n,
    mult_div_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_RUN  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t      state, state_nx;
    logic [1:0]  op_q;
    logic [31:0] rs_q, rt_q;
    logic [31:0] a_mag;      // multiplicand (mult) or divisor (div) magnitude
    logic [63:0] p_q;        // mult: {partial, multiplier}; div: {remainder, quotient}
    logic [5:0]  cnt;
    logic        neg_res;    // product / quotient must be negated
    logic        neg_rem;    // remainder takes a negative dividend's sign
    logic        early_q;    // multiply ends after 16 iterations
    logic [31:0] hi_q, lo_q;

    logic        accept;
    logic        last_iter;
    logic        is_div;
    logic [63:0] p_step;
    logic [32:0] mul_sum;
    logic [32:0] rem_sh;
    logic [32:0] diff;
    logic [63:0] prod;
    logic [31:0] fix_hi, fix_lo;
    logic        sgn_op;
    logic [31:0] rs_mag, rt_mag;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    assign is_div    = op_q[1];
    assign sgn_op    = ~op_q[0];
    assign rs_mag    = sgn_op ? abs32(rs_q) : rs_q;
    assign rt_mag    = sgn_op ? abs32(rt_q) : rt_q;
    assign accept    = (state == S_IDLE) && bus.start && !bus.flush;
    assign last_iter = (cnt == 6'd31) || (early_q && (cnt == 6'd15));

    assign bus.busy  = (state != S_IDLE);
    assign bus.stall = bus.busy || (bus.start && (state == S_IDLE));
    assign bus.done  = (state == S_DONE);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: flush aborts any non-IDLE state and blocks a same-cycle start
    always_comb begin
        state_nx = state;
        if (bus.flush) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (bus.start) state_nx = S_PREP;
                S_PREP:  state_nx = S_RUN;
                S_RUN:   if (last_iter) state_nx = S_FIX;
                S_FIX:   state_nx = S_DONE;
                S_DONE:  state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // One radix-2 step: shift-add multiply or restoring shift-subtract divide
    always_comb begin
        mul_sum = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, a_mag} : 33'd0);
        rem_sh  = {p_q[63:32], p_q[31]};
        diff    = rem_sh - {1'b0, a_mag};
        if (is_div) begin
            if (!diff[32]) p_step = {diff[31:0], p_q[30:0], 1'b1};
            else           p_step = {rem_sh[31:0], p_q[30:0], 1'b0};
        end else begin
            p_step = {mul_sum, p_q[31:1]};
        end
    end

    // Sign fix-up and HI/LO selection; a 16-step multiply leaves the product 16 bits high
    always_comb begin
        prod   = early_q ? {16'd0, p_q[63:16]} : p_q;
        fix_hi = 32'd0;
        fix_lo = 32'd0;
        if (!is_div) begin
            if (neg_res) prod = -prod;
            fix_hi = prod[63:32];
            fix_lo = prod[31:0];
        end else if (rt_q == 32'd0) begin
            fix_hi = rs_q;
            fix_lo = 32'hFFFF_FFFF;
        end else begin
            fix_lo = neg_res ? -p_q[31:0]  : p_q[31:0];
            fix_hi = neg_rem ? -p_q[63:32] : p_q[63:32];
        end
    end

    // Operand latch, iteration datapath and HI/LO write on the FIX->DONE edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= 2'd0;
            rs_q    <= 32'd0;
            rt_q    <= 32'd0;
            a_mag   <= 32'd0;
            p_q     <= 64'd0;
            cnt     <= 6'd0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            early_q <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q <= bus.op;
                        rs_q <= bus.rs_data;
                        rt_q <= bus.rt_data;
                    end
                end
                S_PREP: begin
                    cnt     <= 6'd0;
                    neg_res <= sgn_op && (rs_q[31] ^ rt_q[31]);
                    neg_rem <= sgn_op && rs_q[31];
                    if (is_div) begin
                        a_mag <= rt_mag;
                        p_q   <= {32'd0, rs_mag};
                    end else begin
                        a_mag <= rs_mag;
                        p_q   <= {32'd0, rt_mag};
                    end
`ifdef MULDIV_EARLY_OUT_EN
                    early_q <= !is_div && (rt_mag[31:16] == 16'd0);
`else
                    early_q <= 1'b0;
`endif
                end
                S_RUN: begin
                    p_q <= p_step;
                    cnt <= cnt + 6'd1;
                end
                S_FIX: begin
                    if (!bus.flush) begin
                        hi_q <= fix_hi;
                        lo_q <= fix_lo;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
